// File: rtl/vp_033_pkg.sv
`default_nettype none
//----------------------------------------------------------------------------
// vp_033_pkg - shared constants for the 1801VP1-033 PIO model.  Rev 1.0
//----------------------------------------------------------------------------
package vp_033_pkg;

    localparam logic [3:0]  MODE_PIO      = 4'b0101;
    localparam logic [15:0] BASE_DEFAULT  = 16'o167770;
    localparam logic [15:0] VEC_A_DEFAULT = 16'o000300;
    localparam logic [15:0] VEC_B_DEFAULT = 16'o000304;

    // Word offset within the register window, taken from address bits [2:1]
    typedef enum logic [1:0] {
        REG_CSR  = 2'd0,
        REG_TXD  = 2'd1,
        REG_RXD  = 2'd2,
        REG_NONE = 2'd3
    } reg_sel_e;

    localparam int CSR_BIT_CSR0 = 0;
    localparam int CSR_BIT_CSR1 = 1;
    localparam int CSR_BIT_IEB  = 5;
    localparam int CSR_BIT_IEA  = 6;
    localparam int CSR_BIT_REQA = 7;
    localparam int CSR_BIT_REQB = 15;

    function automatic logic [15:0] csr_pack(
        input logic csr0,
        input logic csr1,
        input logic ieb,
        input logic iea,
        input logic reqa,
        input logic reqb
    );
        logic [15:0] v;
        v               = '0;
        v[CSR_BIT_CSR0] = csr0;
        v[CSR_BIT_CSR1] = csr1;
        v[CSR_BIT_IEB]  = ieb;
        v[CSR_BIT_IEA]  = iea;
        v[CSR_BIT_REQA] = reqa;
        v[CSR_BIT_REQB] = reqb;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vp_033_sync.sv
`default_nettype none
//----------------------------------------------------------------------------
// vp_033_sync - two-flop input synchroniser with async clear to RST_VAL.  Rev 1.0
//----------------------------------------------------------------------------
module vp_033_sync #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/vp_033_pio.sv
`default_nettype none
//----------------------------------------------------------------------------
// vp_033_pio - 1801VP1-033 Q-bus interface, parallel I/O mode slave.  Rev 1.0
//----------------------------------------------------------------------------
module vp_033_pio
    import vp_033_pkg::*;
#(
    parameter logic [15:0] BASE  = BASE_DEFAULT,
    parameter logic [15:0] VEC_A = VEC_A_DEFAULT,
    parameter logic [15:0] VEC_B = VEC_B_DEFAULT
) (
    input  logic        PIN_CLK,
    input  logic        PIN_nINIT,
    input  logic [5:0]  PIN_RC,
    output logic        PIN_RDO,
    inout  wire  [15:0] PIN_nAD,
    input  logic        PIN_nBS,
    input  logic        PIN_nSYNC,
    input  logic        PIN_nWTBT,
    input  logic        PIN_nDOUT,
    input  logic        PIN_nDIN,
    output logic        PIN_nRPLY,
    input  logic        PIN_nIAKI,
    output logic        PIN_nIAKO,
    output logic        PIN_nVIRQ,
    output logic        PIN_nSHIFT,
    output logic        PIN_nOUT,
    output logic        PIN_nSET,
    output logic        PIN_nDI,
    output logic        PIN_nRUN,
    output logic        PIN_nDO,
    output logic        PIN_nDONE,
    input  logic        PIN_nTR,
    input  logic        PIN_nERR
);

    localparam int          SYNC_W   = 29;
    // Active-low strobes idle high, requests/mode/RDI idle low
    localparam logic [28:0] SYNC_RST = {4'b0000, 3'b000, 6'b111111, 16'hFFFF};

    logic [SYNC_W-1:0] raw_in;
    logic [SYNC_W-1:0] syn_in;
    logic [3:0]        mode_s;
    logic              rdi_s, reqb_s, reqa_s, iaki_n_s, din_n_s, dout_n_s;
    logic              wtbt_n_s, sync_n_s, bs_n_s;
    logic [15:0]       ad_n_s;
    logic              unused_rc4;

    assign unused_rc4 = PIN_RC[4];
    assign raw_in = {PIN_RC[3:0], PIN_RC[5], PIN_nERR, PIN_nTR, PIN_nIAKI, PIN_nDIN,
                     PIN_nDOUT, PIN_nWTBT, PIN_nSYNC, PIN_nBS, PIN_nAD};

    vp_033_sync #(
        .WIDTH   (SYNC_W),
        .RST_VAL (SYNC_RST)
    ) u_sync (
        .clk_i  (PIN_CLK),
        .rst_ni (PIN_nINIT),
        .d_i    (raw_in),
        .q_o    (syn_in)
    );

    assign {mode_s, rdi_s, reqb_s, reqa_s, iaki_n_s, din_n_s, dout_n_s,
            wtbt_n_s, sync_n_s, bs_n_s, ad_n_s} = syn_in;

    // ---------------------------------------------------------------- state
    logic     sync_n_q, din_q, dout_q;
    logic     sel_q, sel_d;
    reg_sel_e reg_q, reg_d;
    logic     lane_q, lane_d;
    logic     csr0_q, csr0_d, csr1_q, csr1_d, ieb_q, ieb_d, iea_q, iea_d;
    logic     pend_a_q, pend_a_d, pend_b_q, pend_b_d;
    logic     ena_q, enb_q;
    logic     iack_q, iack_d, win_b_q, win_b_d;
    logic     rdo_q, rdo_d, rply_q, rply_d;
    logic     txw_q, txw_d, run_q, run_d;
    logic     rxr_q, rxr_d, do_q, do_d;

    // ---------------------------------------------------------------- decode
    logic        din, dout, sync_fall, din_fall, dout_rise;
    logic [15:0] bus_val;
    logic        addr_hit;
    logic        is_csr, is_txd, is_rxd;
    logic        byte_wr, low_en, high_en, csr_wr;
    logic        ena, enb, set_a, set_b, ack_end, claim, cyc_act;
    logic [15:0] csr_val, vec_val, ad_drive;
    logic        csr_rd, vec_rd;

    assign din       = ~din_n_s;
    assign dout      = ~dout_n_s;
    assign sync_fall = sync_n_q & ~sync_n_s;
    assign din_fall  = din_q & ~din;
    assign dout_rise = dout & ~dout_q;
    assign bus_val   = ~ad_n_s;

    assign addr_hit = (mode_s == MODE_PIO) && !bs_n_s &&
                      (bus_val[15:3] == BASE[15:3]) && (bus_val[2:1] != 2'b11);

    assign is_csr = sel_q && (reg_q == REG_CSR);
    assign is_txd = sel_q && (reg_q == REG_TXD);
    assign is_rxd = sel_q && (reg_q == REG_RXD);

    assign byte_wr = ~wtbt_n_s;
    assign low_en  = ~byte_wr | ~lane_q;
    assign high_en = ~byte_wr | lane_q;
    // Only the low CSR byte holds writable bits
    assign csr_wr  = is_csr && dout_rise && low_en;

    assign ena     = reqa_s & iea_q;
    assign enb     = reqb_s & ieb_q;
    assign set_a   = ena & ~ena_q;
    assign set_b   = enb & ~enb_q;
    assign ack_end = iack_q & din_fall;
    assign claim   = ~iack_q & ~iaki_n_s & din & (pend_a_q | pend_b_q);
    assign cyc_act = (sel_q & (din | dout)) | (iack_q & din);

    always_comb begin
        sel_d  = sel_q;
        reg_d  = reg_q;
        lane_d = lane_q;
        if (sync_n_s) begin
            sel_d = 1'b0;
        end else if (sync_fall) begin
            sel_d  = addr_hit;
            reg_d  = reg_sel_e'(bus_val[2:1]);
            lane_d = bus_val[0];
        end

        csr0_d = csr0_q;
        csr1_d = csr1_q;
        ieb_d  = ieb_q;
        iea_d  = iea_q;
        if (csr_wr) begin
            csr0_d = bus_val[CSR_BIT_CSR0];
            csr1_d = bus_val[CSR_BIT_CSR1];
            ieb_d  = bus_val[CSR_BIT_IEB];
            iea_d  = bus_val[CSR_BIT_IEA];
        end

        // Later assignments take precedence: a fresh request edge beats an ack
        pend_a_d = pend_a_q;
        if (ack_end && !win_b_q) pend_a_d = 1'b0;
        if (!iea_q)              pend_a_d = 1'b0;
        if (set_a)               pend_a_d = 1'b1;
        pend_b_d = pend_b_q;
        if (ack_end && win_b_q)  pend_b_d = 1'b0;
        if (!ieb_q)              pend_b_d = 1'b0;
        if (set_b)               pend_b_d = 1'b1;

        iack_d  = iack_q;
        win_b_d = win_b_q;
        if (claim) begin
            iack_d  = 1'b1;
            win_b_d = ~pend_a_q;
        end else if (iack_q && !din && iaki_n_s) begin
            iack_d = 1'b0;
        end

        rdo_d  = cyc_act;
        rply_d = cyc_act & rdi_s;

        txw_d = txw_q;
        run_d = 1'b0;
        if (is_txd && dout) begin
            txw_d = 1'b1;
        end else if (txw_q && !dout) begin
            txw_d = 1'b0;
            run_d = 1'b1;
        end

        rxr_d = rxr_q;
        do_d  = 1'b0;
        if (is_rxd && din) begin
            rxr_d = 1'b1;
        end else if (rxr_q && !din) begin
            rxr_d = 1'b0;
            do_d  = 1'b1;
        end
    end

    always_ff @(posedge PIN_CLK or negedge PIN_nINIT) begin
        if (!PIN_nINIT) begin
            sync_n_q <= 1'b1;
            din_q    <= 1'b0;
            dout_q   <= 1'b0;
            sel_q    <= 1'b0;
            reg_q    <= REG_CSR;
            lane_q   <= 1'b0;
            csr0_q   <= 1'b0;
            csr1_q   <= 1'b0;
            ieb_q    <= 1'b0;
            iea_q    <= 1'b0;
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
            ena_q    <= 1'b0;
            enb_q    <= 1'b0;
            iack_q   <= 1'b0;
            win_b_q  <= 1'b0;
            rdo_q    <= 1'b0;
            rply_q   <= 1'b0;
            txw_q    <= 1'b0;
            run_q    <= 1'b0;
            rxr_q    <= 1'b0;
            do_q     <= 1'b0;
        end else begin
            sync_n_q <= sync_n_s;
            din_q    <= din;
            dout_q   <= dout;
            sel_q    <= sel_d;
            reg_q    <= reg_d;
            lane_q   <= lane_d;
            csr0_q   <= csr0_d;
            csr1_q   <= csr1_d;
            ieb_q    <= ieb_d;
            iea_q    <= iea_d;
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
            ena_q    <= ena;
            enb_q    <= enb;
            iack_q   <= iack_d;
            win_b_q  <= win_b_d;
            rdo_q    <= rdo_d;
            rply_q   <= rply_d;
            txw_q    <= txw_d;
            run_q    <= run_d;
            rxr_q    <= rxr_d;
            do_q     <= do_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign csr_val  = csr_pack(csr0_q, csr1_q, ieb_q, iea_q, reqa_s, reqb_s);
    assign vec_val  = win_b_q ? VEC_B : VEC_A;
    assign csr_rd   = is_csr & din;
    assign vec_rd   = iack_q & din;
    assign ad_drive = (csr_rd ? csr_val : 16'h0000) | (vec_rd ? vec_val : 16'h0000);

    // The bus is inverted and wired-OR: a one bit pulls its line low, zeros float
    for (genvar i = 0; i < 16; i++) begin : g_nad
        assign PIN_nAD[i] = ad_drive[i] ? 1'b0 : 1'bz;
    end

    assign PIN_RDO    = rdo_q;
    assign PIN_nRPLY  = rply_q ? 1'b0 : 1'bz;
    assign PIN_nVIRQ  = (pend_a_q | pend_b_q) ? 1'b0 : 1'bz;
    assign PIN_nIAKO  = (iack_q | pend_a_q | pend_b_q) ? 1'b1 : iaki_n_s;
    assign PIN_nSHIFT = ~csr0_q;
    assign PIN_nOUT   = ~csr1_q;
    assign PIN_nSET   = ~(is_txd & dout & low_en);
    assign PIN_nDI    = ~(is_txd & dout & high_en);
    assign PIN_nRUN   = ~run_q;
    assign PIN_nDO    = ~do_q;
    assign PIN_nDONE  = ~(is_rxd & din);

endmodule
`default_nettype wire

// File: tb/tb_vp_033_pio.sv
`default_nettype none
//----------------------------------------------------------------------------
// tb_vp_033_pio - directed and randomized bus cycles against a register model.  Rev 1.0
//----------------------------------------------------------------------------
module tb_vp_033_pio;
    import vp_033_pkg::*;

    localparam logic [15:0] A_CSR = 16'o167770;
    localparam logic [15:0] A_TXD = 16'o167772;
    localparam logic [15:0] A_RXD = 16'o167774;
    localparam logic [15:0] A_BAD = 16'o167776;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        ninit = 1'b0;
    logic [3:0]  mode  = MODE_PIO;
    logic        nbs = 1'b1, nsync = 1'b1, nwtbt = 1'b1, ndout = 1'b1, ndin = 1'b1;
    logic        niaki = 1'b1, req_a = 1'b0, req_b = 1'b0;
    logic        m_oe = 1'b0;
    logic [15:0] m_val = 16'h0000;

    wire [15:0] bus_nad;
    wire        w_rdo, w_nrply, w_niako, w_nvirq, w_nshift, w_nout;
    wire        w_nset, w_ndi, w_nrun, w_ndo, w_ndone;
    wire [5:0]  w_rc = {w_rdo, 1'b0, mode};

    assign bus_nad = m_oe ? m_val : 16'hzzzz;
    pullup (w_nrply);
    pullup (w_nvirq);
    for (genvar gi = 0; gi < 16; gi++) begin : g_pu
        pullup (bus_nad[gi]);
    end

    vp_033_pio dut (
        .PIN_CLK    (clk),
        .PIN_nINIT  (ninit),
        .PIN_RC     (w_rc),
        .PIN_RDO    (w_rdo),
        .PIN_nAD    (bus_nad),
        .PIN_nBS    (nbs),
        .PIN_nSYNC  (nsync),
        .PIN_nWTBT  (nwtbt),
        .PIN_nDOUT  (ndout),
        .PIN_nDIN   (ndin),
        .PIN_nRPLY  (w_nrply),
        .PIN_nIAKI  (niaki),
        .PIN_nIAKO  (w_niako),
        .PIN_nVIRQ  (w_nvirq),
        .PIN_nSHIFT (w_nshift),
        .PIN_nOUT   (w_nout),
        .PIN_nSET   (w_nset),
        .PIN_nDI    (w_ndi),
        .PIN_nRUN   (w_nrun),
        .PIN_nDO    (w_ndo),
        .PIN_nDONE  (w_ndone),
        .PIN_nTR    (req_a),
        .PIN_nERR   (req_b)
    );

    // Low-cycle counters for the peripheral strobes
    int n_set = 0, n_di = 0, n_run = 0, n_do = 0, n_done = 0, n_iako_lo = 0;
    always @(negedge clk) begin
        if (w_nset  === 1'b0) n_set++;
        if (w_ndi   === 1'b0) n_di++;
        if (w_nrun  === 1'b0) n_run++;
        if (w_ndo   === 1'b0) n_do++;
        if (w_ndone === 1'b0) n_done++;
        if (niaki === 1'b0 && w_niako === 1'b0) n_iako_lo++;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
        end
    endtask

    // Register model: CSR bits, request levels, pending flags
    bit m_csr0, m_csr1, m_ieb, m_iea, m_pa, m_pb, m_ea_prev, m_eb_prev;

    function automatic logic [15:0] model_csr();
        return (16'(req_b) << 15) | (16'(req_a) << 7) | (16'(m_iea) << 6) |
               (16'(m_ieb) << 5) | (16'(m_csr1) << 1) | 16'(m_csr0);
    endfunction

    task automatic model_eval();
        bit ea, eb;
        ea = req_a & m_iea;
        eb = req_b & m_ieb;
        if (!m_iea) m_pa = 1'b0;
        if (!m_ieb) m_pb = 1'b0;
        if (ea && !m_ea_prev) m_pa = 1'b1;
        if (eb && !m_eb_prev) m_pb = 1'b1;
        m_ea_prev = ea;
        m_eb_prev = eb;
    endtask

    task automatic model_write(input bit bw, input bit lane, input logic [15:0] d);
        if (!bw || !lane) begin
            m_csr0 = d[0];
            m_csr1 = d[1];
            m_ieb  = d[5];
            m_iea  = d[6];
        end
        model_eval();
    endtask

    task automatic model_reset();
        {m_csr0, m_csr1, m_ieb, m_iea, m_pa, m_pb, m_ea_prev, m_eb_prev} = '0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_reply(output bit replied);
        replied = 1'b0;
        for (int i = 0; i < 24 && !replied; i++) begin
            @(negedge clk);
            if (w_nrply === 1'b0) replied = 1'b1;
        end
    endtask

    task automatic bus_cycle(input logic [15:0] addr, input bit wr, input bit bw,
                             input logic [15:0] wdata, output logic [15:0] rdata,
                             output bit replied);
        rdata = 16'h0000;
        tick(1);
        m_val = ~addr; m_oe = 1'b1; nbs = 1'b0; nwtbt = wr ? 1'b0 : 1'b1;
        tick(2);
        nsync = 1'b0;
        tick(2);
        if (wr) begin
            m_val = ~wdata; nwtbt = bw ? 1'b0 : 1'b1;
            tick(1);
            ndout = 1'b0;
        end else begin
            m_oe = 1'b0; nwtbt = 1'b1; ndin = 1'b0;
        end
        wait_reply(replied);
        if (replied) begin
            repeat (2) @(negedge clk);
            rdata = ~bus_nad;
        end
        tick(1);
        ndin = 1'b1; ndout = 1'b1; m_oe = 1'b0; nwtbt = 1'b1;
        if (replied) begin
            for (int i = 0; i < 12 && w_nrply === 1'b0; i++) @(negedge clk);
            chk("rply_release", w_nrply, 1'b1);
        end
        tick(1);
        nsync = 1'b1; nbs = 1'b1;
        tick(8);
    endtask

    task automatic iack_cycle(output logic [15:0] vec, output bit replied);
        vec = 16'h0000;
        tick(1);
        niaki = 1'b0;
        tick(1);
        ndin = 1'b0;
        wait_reply(replied);
        if (replied) begin
            repeat (2) @(negedge clk);
            vec = ~bus_nad;
        end
        tick(1);
        ndin = 1'b1;
        if (replied) begin
            for (int i = 0; i < 12 && w_nrply === 1'b0; i++) @(negedge clk);
            chk("iack_rply_release", w_nrply, 1'b1);
        end
        tick(3);
        niaki = 1'b1;
        tick(8);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        bit          rp;
        int          s0, s1, s2, s3;
        model_reset();

        // Reset state
        tick(3);
        @(negedge clk);
        chk("rst_rdo", w_rdo, 1'b0);
        chk("rst_nrply", w_nrply, 1'b1);
        chk("rst_nvirq", w_nvirq, 1'b1);
        chk("rst_niako", w_niako, 1'b1);
        chk("rst_nad", bus_nad, 16'hFFFF);
        chk("rst_strobes", {w_nshift, w_nout, w_nset, w_ndi, w_nrun, w_ndo, w_ndone}, 7'h7F);
        tick(1);
        ninit = 1'b1;
        tick(3);

        bus_cycle(A_CSR, 0, 0, 0, rd, rp);
        chk("csr_rply0", rp, 1'b1);  chk("csr_rd0", rd, 16'o000000);
        bus_cycle(A_RXD, 0, 0, 0, rd, rp);
        chk("rxd_rply0", rp, 1'b1);  chk("rxd_rd0", rd, 16'o000000);
        bus_cycle(A_TXD, 0, 0, 0, rd, rp);
        chk("txd_rply0", rp, 1'b1);  chk("txd_rd0", rd, 16'o000000);
        chk("nshift0", w_nshift, 1'b1);
        chk("nout0", w_nout, 1'b1);

        bus_cycle(A_CSR, 1, 0, 16'o000143, rd, rp);
        model_write(0, 0, 16'o000143);
        chk("csr_wr_rply", rp, 1'b1);
        bus_cycle(A_CSR, 0, 0, 0, rd, rp);
        chk("csr_rd143", rd, 16'o000143);
        chk("nshift1", w_nshift, 1'b0);
        chk("nout1", w_nout, 1'b0);

        // Channel B request and acknowledge
        req_b = 1'b1; model_eval(); tick(6);
        bus_cycle(A_CSR, 0, 0, 0, rd, rp);
        chk("csr_rd_reqb", rd, 16'o100143);
        chk("nvirq_b", w_nvirq, 1'b0);
        s0 = n_iako_lo;
        iack_cycle(rd, rp);
        chk("iack_b_rply", rp, 1'b1);
        chk("iack_b_vec", rd, 16'o000304);
        chk("iako_held_b", n_iako_lo - s0, 0);
        m_pb = 1'b0;
        chk("nvirq_b_rel", w_nvirq, 1'b1);

        // Channel A request and acknowledge
        req_b = 1'b0; req_a = 1'b1; model_eval(); tick(6);
        bus_cycle(A_CSR, 0, 0, 0, rd, rp);
        chk("csr_rd_reqa", rd, 16'o000343);
        chk("nvirq_a", w_nvirq, 1'b0);
        iack_cycle(rd, rp);
        chk("iack_a_vec", rd, 16'o000300);
        m_pa = 1'b0;
        chk("nvirq_a_rel", w_nvirq, 1'b1);

        // No pending: acknowledge passes down the chain
        tick(1); niaki = 1'b0; tick(5);
        chk("iako_pass_lo", w_niako, 1'b0);
        niaki = 1'b1; tick(4);
        chk("iako_pass_hi", w_niako, 1'b1);

        // TXD word write, then low-byte write
        s0 = n_set; s1 = n_di; s2 = n_run;
        bus_cycle(A_TXD, 1, 0, 16'o000000, rd, rp);
        chk("txd_wr_rply", rp, 1'b1);
        chk("txd_nset", (n_set - s0) > 0, 1'b1);
        chk("txd_ndi", (n_di - s1) > 0, 1'b1);
        chk("txd_nrun", n_run - s2, 1);
        s0 = n_set; s1 = n_di; s2 = n_run;
        bus_cycle(A_TXD, 1, 1, 16'o000377, rd, rp);
        chk("txdb_nset", (n_set - s0) > 0, 1'b1);
        chk("txdb_ndi", n_di - s1, 0);
        chk("txdb_nrun", n_run - s2, 1);

        // RXD read strobes
        s0 = n_done; s1 = n_do;
        bus_cycle(A_RXD, 0, 0, 0, rd, rp);
        chk("rxd_rply", rp, 1'b1);
        chk("rxd_ndone", (n_done - s0) > 0, 1'b1);
        chk("rxd_ndo", n_do - s1, 1);

        // Non-decoded accesses
        mode = 4'b0100; tick(4);
        bus_cycle(A_CSR, 0, 0, 0, rd, rp);
        chk("bad_mode_norply", rp, 1'b0);
        mode = MODE_PIO; tick(4);
        bus_cycle(A_BAD, 0, 0, 0, rd, rp);
        chk("bad_addr_norply", rp, 1'b0);

        // Randomized CSR traffic, request changes and acknowledges
        for (int it = 0; it < 24; it++) begin
            int          op;
            bit          lane;
            logic [15:0] wd;
            op   = int'($urandom_range(0, 3));
            lane = 1'($urandom_range(0, 1));
            wd   = 16'($urandom);
            case (op)
                0: begin
                    bus_cycle(A_CSR, 1, 0, wd, rd, rp);
                    model_write(0, 0, wd);
                end
                1: begin
                    bus_cycle(A_CSR | 16'(lane), 1, 1, wd, rd, rp);
                    model_write(1, lane, wd);
                end
                2: begin
                    tick(1);
                    req_a = 1'($urandom_range(0, 1));
                    req_b = 1'($urandom_range(0, 1));
                    model_eval();
                    tick(6);
                end
                default: begin
                    if (m_pa || m_pb) begin
                        iack_cycle(rd, rp);
                        chk("rnd_iack_vec", rd, m_pa ? VEC_A_DEFAULT : VEC_B_DEFAULT);
                        if (m_pa) m_pa = 1'b0;
                        else      m_pb = 1'b0;
                    end
                end
            endcase
            bus_cycle(A_CSR, 0, 0, 0, rd, rp);
            chk("rnd_csr", rd, model_csr());
            chk("rnd_nvirq", w_nvirq, !(m_pa || m_pb));
        end

        // Reset in the middle of a CSR read
        tick(1);
        m_val = ~A_CSR; m_oe = 1'b1; nbs = 1'b0;
        tick(2); nsync = 1'b0;
        tick(2); m_oe = 1'b0; ndin = 1'b0;
        wait_reply(rp);
        chk("mid_rply", rp, 1'b1);
        tick(1);
        ninit = 1'b0;
        #2;
        chk("mid_rst_nrply", w_nrply, 1'b1);
        chk("mid_rst_nad", bus_nad, 16'hFFFF);
        chk("mid_rst_nvirq", w_nvirq, 1'b1);
        tick(1);
        ndin = 1'b1; nsync = 1'b1; nbs = 1'b1;
        tick(2);
        ninit = 1'b1;
        model_reset();
        tick(4);
        bus_cycle(A_CSR, 0, 0, 0, rd, rp);
        chk("post_rst_csr", rd, model_csr());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
